drag_tree_sequencer: RTL and testbench
======================================

DRAG_TREE_SEQUENCER -- requirements
Module: drag_tree_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 25000000, clock cycles per tree step (0.5 s at 50 MHz); legal range 2 and above.
REQ-002 Parameter TICK_CYCLES, default 50000, clock cycles per reaction-time tick (1 ms at 50 MHz); legal range 1 and above.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  synchronous request to begin a run; sampled each clk edge.
REQ-006 Port racerGo  input  1  racer launch input, already debounced and synchronous to clk; active high.
REQ-007 Port preStage  output  1  light-on signal for the pre-stage lamp.
REQ-008 Port stageLight  output  1  light-on signal for the stage lamp.
REQ-009 Port amber  output  3  light-on signals for amber lamps, bit 0 top, bit 2 bottom.
REQ-010 Port green  output  1  light-on signal for the green lamp.
REQ-011 Port red  output  1  light-on signal for the foul (red) lamp.
REQ-012 Port reactionTime  output  16  reaction time in ticks, valid when done is high.
REQ-013 Port done  output  1  high while a finished result (valid time or foul) is being held.

Function
REQ-014 States: IDLE, STAGED, AMBER1, AMBER2, AMBER3, GREEN, FOUL, RESULT; all outputs are registered.
REQ-015 IDLE: preStage=1, all other lamps=0, done=0; start=1 moves to STAGED, loads the step counter with 0, and clears reactionTime to 0.
REQ-016 STAGED: preStage=1, stageLight=1; after exactly STEP_CYCLES cycles in the state, move to AMBER1.
REQ-017 AMBERn (n=1..3): preStage=1, stageLight=1, only amber bit n-1 on; each state lasts exactly STEP_CYCLES cycles; AMBER3 moves to GREEN.
REQ-018 GREEN: green=1, amber=0, preStage=1, stageLight=1; reactionTime increments by 1 every TICK_CYCLES cycles and saturates at 16'hFFFF.
REQ-019 The first cycle in GREEN with racerGo=1 moves to RESULT, freezing reactionTime; racerGo high in the first GREEN cycle gives reactionTime=0.
REQ-020 racerGo=1 in any cycle of STAGED or AMBER1..3 moves to FOUL on the next edge; the foul takes priority over the step-timer expiry in the same cycle.
REQ-021 FOUL: red=1, green=0, amber=0, stageLight=1, done=1, reactionTime=16'hFFFF.
REQ-022 RESULT: green=1, stageLight=1, done=1, reactionTime held.
REQ-023 From FOUL or RESULT, start=1 returns to IDLE (lamps per REQ-015, done=0); the held result is discarded.
REQ-024 start is ignored in STAGED, AMBER1..3 and GREEN; the run is not restarted.
REQ-025 racerGo is ignored in IDLE, FOUL and RESULT.
REQ-026 The step counter and the tick counter clear on every state entry, so each state timing starts fresh.
REQ-027 Simultaneous start and racerGo in IDLE: start wins and the run begins; racerGo in that cycle is not a foul.

Reset
REQ-028 rst_n=0 forces IDLE immediately, regardless of clk, from any state including mid-amber and mid-GREEN.
REQ-029 Values while in reset: preStage=1, stageLight=0, amber=3'b000, green=0, red=0, done=0, reactionTime=16'h0000, both counters=0.
REQ-030 After rst_n rises, the first state change requires start=1 sampled on a clk edge.

Verification (STEP_CYCLES=4, TICK_CYCLES=2)
REQ-031 Clean run: pulse start; racerGo rises 6 cycles after GREEN entry -> amber bits 0,1,2 each on for 4 cycles; done=1; reactionTime=3; red=0.
REQ-032 Foul: racerGo=1 during AMBER2 -> next edge red=1, amber=0, green=0, done=1, reactionTime=16'hFFFF; a later start pulse returns to IDLE.
REQ-033 Saturation: hold racerGo=0 in GREEN for at least 131072 cycles -> reactionTime stops at 16'hFFFF; racerGo=1 -> RESULT with 16'hFFFF, red=0.
REQ-034 Async reset: assert rst_n=0 mid-GREEN between clk edges -> outputs match REQ-029 with no clk edge needed.
REQ-035 Priority: start and racerGo both high in IDLE -> STAGED, no foul; start pulsed during AMBER1 -> sequence unaffected.

Source files
------------

// File: rtl/drag_tree_sequencer.sv
// Drag-strip christmas tree sequencer: stage -> three ambers -> green, with
// foul detection on early launch and a saturating reaction-time counter.
module drag_tree_sequencer #(
  parameter int STEP_CYCLES = 25000000,
  parameter int TICK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        racerGo,
  output logic        preStage,
  output logic        stageLight,
  output logic [2:0]  amber,
  output logic        green,
  output logic        red,
  output logic [15:0] reactionTime,
  output logic        done
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, STAGED, AMBER1, AMBER2, AMBER3, GREEN, FOUL, RESULT
  } state_t;

  typedef struct packed {
    logic       pre;
    logic       stage;
    logic [2:0] amber;
    logic       green;
    logic       red;
    logic       done;
  } lamps_t;

  state_t        state, state_nx;
  logic [SW-1:0] step_cnt;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   rt, rt_nx;
  lamps_t        lamps, lamps_nx;

  function automatic lamps_t decode(state_t s);
    lamps_t l;
    l = '{pre: 1'b1, stage: 1'b0, amber: 3'b000, green: 1'b0, red: 1'b0, done: 1'b0};
    case (s)
      STAGED: l.stage = 1'b1;
      AMBER1: begin l.stage = 1'b1; l.amber = 3'b001; end
      AMBER2: begin l.stage = 1'b1; l.amber = 3'b010; end
      AMBER3: begin l.stage = 1'b1; l.amber = 3'b100; end
      GREEN:  begin l.stage = 1'b1; l.green = 1'b1; end
      FOUL:   begin l.stage = 1'b1; l.red = 1'b1; l.done = 1'b1; end
      RESULT: begin l.stage = 1'b1; l.green = 1'b1; l.done = 1'b1; end
      default: ;
    endcase
    return l;
  endfunction

  wire step_last = (step_cnt == STEP_LAST);
  wire tick_last = (tick_cnt == TICK_LAST);
  wire entering  = (state_nx != state);
  wire timed     = (state == STAGED) || (state == AMBER1) ||
                   (state == AMBER2) || (state == AMBER3);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = STAGED;
      STAGED: if (racerGo) state_nx = FOUL; else if (step_last) state_nx = AMBER1;
      AMBER1: if (racerGo) state_nx = FOUL; else if (step_last) state_nx = AMBER2;
      AMBER2: if (racerGo) state_nx = FOUL; else if (step_last) state_nx = AMBER3;
      AMBER3: if (racerGo) state_nx = FOUL; else if (step_last) state_nx = GREEN;
      GREEN:  if (racerGo) state_nx = RESULT;
      FOUL, RESULT: if (start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A launch in the same cycle as a tick edge freezes the time before it counts.
  always_comb begin
    rt_nx = rt;
    if (state_nx == FOUL)
      rt_nx = 16'hFFFF;
    else if (state_nx == IDLE || (state == IDLE && start))
      rt_nx = 16'h0000;
    else if (state == GREEN && !racerGo && tick_last && rt != 16'hFFFF)
      rt_nx = rt + 16'd1;
  end

  assign lamps_nx = decode(state_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
      tick_cnt <= '0;
      rt       <= 16'h0000;
      lamps    <= decode(IDLE);
    end else begin
      state    <= state_nx;
      step_cnt <= (entering || !timed) ? '0 : step_cnt + SW'(1);
      tick_cnt <= (entering || state != GREEN || tick_last) ? '0 : tick_cnt + TW'(1);
      rt       <= rt_nx;
      lamps    <= lamps_nx;
    end
  end

  assign preStage     = lamps.pre;
  assign stageLight   = lamps.stage;
  assign amber        = lamps.amber;
  assign green        = lamps.green;
  assign red          = lamps.red;
  assign done         = lamps.done;
  assign reactionTime = rt;

endmodule

// File: tb/tb_drag_tree_sequencer.sv
// Directed bench for drag_tree_sequencer: timing, foul, priority, reset, saturation.
module tb_drag_tree_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, racerGo, start2, racerGo2;
  logic preStage, stageLight, green, red, done;
  logic preStage2, stageLight2, green2, red2, done2;
  logic [2:0] amber, amber2;
  logic [15:0] rt, rt2;
  int nchk = 0, nfail = 0;

  localparam logic [7:0] L_IDLE = 8'b1_0_000_0_0_0;
  localparam logic [7:0] L_ST   = 8'b1_1_000_0_0_0;
  localparam logic [7:0] L_A1   = 8'b1_1_001_0_0_0;
  localparam logic [7:0] L_A2   = 8'b1_1_010_0_0_0;
  localparam logic [7:0] L_A3   = 8'b1_1_100_0_0_0;
  localparam logic [7:0] L_GRN  = 8'b1_1_000_1_0_0;
  localparam logic [6:0] L_FOUL = 7'b1_000_0_1_1;
  localparam logic [6:0] L_RES  = 7'b1_000_1_0_1;

  wire [7:0] lamps  = {preStage, stageLight, amber, green, red, done};
  wire [7:0] lamps2 = {preStage2, stageLight2, amber2, green2, red2, done2};

  always #5 clk = ~clk;

  drag_tree_sequencer #(.STEP_CYCLES(4), .TICK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .racerGo(racerGo),
    .preStage(preStage), .stageLight(stageLight), .amber(amber), .green(green),
    .red(red), .reactionTime(rt), .done(done));

  drag_tree_sequencer #(.STEP_CYCLES(2), .TICK_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .racerGo(racerGo2),
    .preStage(preStage2), .stageLight(stageLight2), .amber(amber2), .green(green2),
    .red(red2), .reactionTime(rt2), .done(done2));

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_amber(input logic [2:0] a, input string nm);
    for (int i = 0; i < 60 && amber !== a; i++) @(negedge clk);
    nchk++;
    if (amber !== a) begin nfail++; $display("FAIL %s timeout: amber=%b want %b", nm, amber, a); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; racerGo = 0; start2 = 0; racerGo2 = 0;
    #2 rst_n = 1'b0;
    #1 nchk++;
    if (lamps !== L_IDLE || rt !== 16'h0) begin
      nfail++; $display("FAIL reset_state: lamps=%b rt=%h want %b 0000", lamps, rt, L_IDLE);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if (lamps !== L_IDLE) begin nfail++; $display("FAIL idle_no_start: lamps=%b want %b", lamps, L_IDLE); end
  endtask

  task automatic test_clean_run();
    int n_st = 0, n_a1 = 0, n_a2 = 0, n_a3 = 0;
    pulse_start();
    for (int i = 0; i < 40 && !green; i++) begin
      if (lamps === L_ST) n_st++;
      if (lamps === L_A1) n_a1++;
      if (lamps === L_A2) n_a2++;
      if (lamps === L_A3) n_a3++;
      @(negedge clk);
    end
    nchk++;
    if ({n_st, n_a1, n_a2, n_a3} !== {32'd4, 32'd4, 32'd4, 32'd4}) begin
      nfail++; $display("FAIL step_lengths: st=%0d a1=%0d a2=%0d a3=%0d want 4 each", n_st, n_a1, n_a2, n_a3);
    end
    nchk++;
    if (lamps !== L_GRN || rt !== 16'd0) begin
      nfail++; $display("FAIL green_entry: lamps=%b rt=%0d want %b 0", lamps, rt, L_GRN);
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        nchk++;
        if (rt !== 16'd2) begin nfail++; $display("FAIL green_tick: rt=%0d want 2", rt); end
      end
    end
    racerGo = 1'b1;
    @(negedge clk) racerGo = 1'b0;
    nchk++;
    if (lamps[6:0] !== L_RES || rt !== 16'd3) begin
      nfail++; $display("FAIL clean_result: lamps=%b rt=%0d want %b 3", lamps[6:0], rt, L_RES);
    end
    racerGo = 1'b1;
    repeat (4) @(negedge clk);
    racerGo = 1'b0;
    nchk++;
    if (lamps[6:0] !== L_RES || rt !== 16'd3) begin
      nfail++; $display("FAIL result_hold: lamps=%b rt=%0d want %b 3", lamps[6:0], rt, L_RES);
    end
    pulse_start();
    nchk++;
    if (lamps !== L_IDLE || rt !== 16'd0) begin
      nfail++; $display("FAIL result_to_idle: lamps=%b rt=%0d want %b 0", lamps, rt, L_IDLE);
    end
  endtask

  task automatic test_foul();
    pulse_start();
    wait_amber(3'b010, "foul_reach_a2");
    @(negedge clk) racerGo = 1'b1;
    @(negedge clk) racerGo = 1'b0;
    nchk++;
    if (lamps[6:0] !== L_FOUL || rt !== 16'hFFFF) begin
      nfail++; $display("FAIL foul_a2: lamps=%b rt=%h want %b ffff", lamps[6:0], rt, L_FOUL);
    end
    pulse_start();
    nchk++;
    if (lamps !== L_IDLE) begin nfail++; $display("FAIL foul_to_idle: lamps=%b want %b", lamps, L_IDLE); end
  endtask

  task automatic test_foul_priority();
    pulse_start();
    wait_amber(3'b001, "prio_reach_a1");
    repeat (3) @(negedge clk);
    racerGo = 1'b1;
    @(negedge clk) racerGo = 1'b0;
    nchk++;
    if (lamps[6:0] !== L_FOUL) begin
      nfail++; $display("FAIL foul_over_expiry: lamps=%b want %b", lamps[6:0], L_FOUL);
    end
    pulse_start();
  endtask

  task automatic test_back_to_back();
    @(negedge clk) begin start = 1'b1; racerGo = 1'b1; end
    @(negedge clk) begin start = 1'b0; racerGo = 1'b0; end
    nchk++;
    if (lamps !== L_ST) begin nfail++; $display("FAIL start_beats_go: lamps=%b want %b", lamps, L_ST); end
    wait_amber(3'b001, "b2b_reach_a1");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    nchk++;
    if (lamps !== L_A1) begin nfail++; $display("FAIL start_ignored_a1: lamps=%b want %b", lamps, L_A1); end
    @(negedge clk);
    nchk++;
    if (lamps !== L_A2) begin nfail++; $display("FAIL a1_to_a2: lamps=%b want %b", lamps, L_A2); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 40 && !green; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    nchk++;
    if (lamps !== L_GRN || rt !== 16'd1) begin
      nfail++; $display("FAIL pre_reset_green: lamps=%b rt=%0d want %b 1", lamps, rt, L_GRN);
    end
    #2 rst_n = 1'b0;
    #1 nchk++;
    if (lamps !== L_IDLE || rt !== 16'd0) begin
      nfail++; $display("FAIL async_reset: lamps=%b rt=%0d want %b 0", lamps, rt, L_IDLE);
    end
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    nchk++;
    if (lamps !== L_ST) begin nfail++; $display("FAIL restart_after_reset: lamps=%b want %b", lamps, L_ST); end
  endtask

  task automatic test_saturation();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 0; i < 20 && !green2; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    nchk++;
    if (lamps2 !== L_GRN || rt2 !== 16'd100) begin
      nfail++; $display("FAIL sat_count100: lamps=%b rt=%0d want %b 100", lamps2, rt2, L_GRN);
    end
    repeat (65500) @(negedge clk);
    nchk++;
    if (rt2 !== 16'hFFFF) begin nfail++; $display("FAIL sat_stop: rt=%h want ffff", rt2); end
    racerGo2 = 1'b1;
    @(negedge clk) racerGo2 = 1'b0;
    nchk++;
    if (lamps2[6:0] !== L_RES || rt2 !== 16'hFFFF) begin
      nfail++; $display("FAIL sat_result: lamps=%b rt=%h want %b ffff", lamps2[6:0], rt2, L_RES);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_foul();
    test_foul_priority();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
